// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART definitions for the transmitter and the receiver.
//            Holds the transmitter state encoding and the frame and baud
//            counter widths.
// Macros   : UART_TX_PARITY_EN adds the PARITY state to the encoding.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  localparam int UART_DATA_W = 8;
  localparam int UART_COMP_W = 16;

  typedef enum logic [2:0] {
    TX_IDLE   = 3'd0,
    TX_START  = 3'd1,
    TX_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    TX_PARITY = 3'd3,
`endif
    TX_STOP   = 3'd4
  } tx_state_e;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_baud_cnt.sv
`default_nettype none
// ============================================================================
// Module   : uart_baud_cnt
// Purpose  : Bit-time counter. Counts 0..comp and flags the last cycle of
//            each bit, so one bit lasts comp+1 clock cycles.
// Ports    : clk     - clock
//            rstn    - asynchronous active-low reset
//            clr     - synchronous clear, holds the count at zero
//            comp    - baud compare value (unsigned)
//            bit_end - high in the final cycle of the current bit
// Revision : 1.0 - initial release
// ============================================================================
module uart_baud_cnt
  import uart_pkg::*;
(
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   clr,
  input  logic [UART_COMP_W-1:0] comp,
  output logic                   bit_end
);

  logic [UART_COMP_W-1:0] cnt_q;
  logic [UART_COMP_W-1:0] cnt_d;

  // '>=' rather than '==' so that lowering comp mid-bit below the current
  // count ends the bit at once instead of wrapping through 2^16 cycles.
  assign bit_end = ~clr & (cnt_q >= comp);

  always_comb begin
    cnt_d = cnt_q + UART_COMP_W'(1);
    if (clr || bit_end) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule : uart_baud_cnt
`default_nettype wire

// File: rtl/uart_transmitter.sv
`default_nettype none
// ============================================================================
// Module   : uart_transmitter
// Purpose  : UART transmitter, 8 data bits LSB first, 1 start, 1 stop bit.
//            Accepts a byte with a request/acknowledge handshake and shifts
//            it out on a registered, idle-high line.
// Ports    : clk     - clock, all state changes on the rising edge
//            rstn    - asynchronous active-low reset
//            tr_en   - transmitter enable; low aborts and forces idle
//            comp    - baud compare value, each bit lasts comp+1 cycles
//            tx_data - byte to send, sampled only while tx_ack is high
//            tx_req  - send request level, held until tx_ack
//            tx_ack  - one-cycle pulse, tx_data accepted
//            tx_busy - high while a frame is in progress
//            uart_tx - serial output line
// Macros   : UART_TX_PARITY_EN - insert an even-parity bit before the stop
//            bit (11-bit frame). Undefined gives a 10-bit frame.
// Revision : 1.0 - initial release
// ============================================================================
module uart_transmitter
  import uart_pkg::*;
(
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   tr_en,
  input  logic [UART_COMP_W-1:0] comp,
  input  logic [UART_DATA_W-1:0] tx_data,
  input  logic                   tx_req,
  output logic                   tx_ack,
  output logic                   tx_busy,
  output logic                   uart_tx
);

  localparam logic [3:0] c_LAST_BIT = 4'(UART_DATA_W - 1);

  tx_state_e              state_q;
  tx_state_e              state_d;
  logic [UART_DATA_W-1:0] shift_q;
  logic [UART_DATA_W-1:0] shift_d;
  logic [3:0]             bitcnt_q;
  logic [3:0]             bitcnt_d;
  logic                   uart_tx_q;
  logic                   uart_tx_d;
  logic                   ready_q;
  logic                   accept;
  logic                   bit_end;
  logic                   baud_clr;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q;
  logic                   parity_d;
`endif

  // ready_q stays low through reset and the first edge after it, so no
  // request can be accepted on the edge that immediately follows release.
  assign accept   = ready_q & tr_en & tx_req & (state_q == TX_IDLE);
  assign baud_clr = ~tr_en | (state_q == TX_IDLE);

  uart_baud_cnt u_baud_cnt (
    .clk     (clk),
    .rstn    (rstn),
    .clr     (baud_clr),
    .comp    (comp),
    .bit_end (bit_end)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= TX_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (!tr_en) begin
      state_d = TX_IDLE;
    end else begin
      case (state_q)
        TX_IDLE: begin
          if (accept) state_d = TX_START;
        end
        TX_START: begin
          if (bit_end) state_d = TX_DATA;
        end
        TX_DATA: begin
          if (bit_end && (bitcnt_q == c_LAST_BIT)) begin
`ifdef UART_TX_PARITY_EN
            state_d = TX_PARITY;
`else
            state_d = TX_STOP;
`endif
          end
        end
`ifdef UART_TX_PARITY_EN
        TX_PARITY: begin
          if (bit_end) state_d = TX_STOP;
        end
`endif
        TX_STOP: begin
          if (bit_end) state_d = TX_IDLE;
        end
        default: state_d = TX_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FSM: outputs. The line register is loaded with the level belonging to
  // the state being entered, so uart_tx changes on the same edge as the
  // state and the start bit follows the ack cycle by exactly one clock.
  // --------------------------------------------------------------------------
  always_comb begin
    tx_ack    = accept;
    tx_busy   = (state_q != TX_IDLE);
    uart_tx_d = 1'b1;
    case (state_d)
      TX_START:  uart_tx_d = 1'b0;
      TX_DATA:   uart_tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      TX_PARITY: uart_tx_d = parity_q;
`endif
      default:   uart_tx_d = 1'b1;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: shift register and bit counter
  // --------------------------------------------------------------------------
  always_comb begin
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif
    if (!tr_en) begin
      shift_d  = '0;
      bitcnt_d = '0;
`ifdef UART_TX_PARITY_EN
      parity_d = 1'b0;
`endif
    end else if (accept) begin
      shift_d  = tx_data;
      bitcnt_d = '0;
`ifdef UART_TX_PARITY_EN
      // Parity is taken from the accepted byte because the shift register
      // no longer holds it once the data bits have gone out.
      parity_d = ^tx_data;
`endif
    end else if ((state_q == TX_DATA) && bit_end) begin
      shift_d  = shift_q >> 1;
      bitcnt_d = bitcnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shift_q   <= '0;
      bitcnt_q  <= '0;
      uart_tx_q <= 1'b1;
      ready_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      shift_q   <= shift_d;
      bitcnt_q  <= bitcnt_d;
      uart_tx_q <= uart_tx_d;
      ready_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_q  <= parity_d;
`endif
    end
  end

  assign uart_tx = uart_tx_q;

endmodule : uart_transmitter
`default_nettype wire

// File: tb/tb_uart_transmitter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_uart_transmitter
// Purpose  : Self-checking bench for uart_transmitter. Expected line
//            waveforms come from a frame model (start, data LSB first,
//            optional even parity, stop; each bit comp+1 cycles).
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_transmitter;

  typedef bit bitq_t[$];

  typedef struct {
    logic [7:0]  data;
    int          cv;
    logic [10:0] seq;     // seq[i] is the i-th transmitted bit
    int          nbits;
    int          cycles;  // expected tx_busy high cycles
  } vec_t;

`ifdef UART_TX_PARITY_EN
  localparam int FL = 11;
`else
  localparam int FL = 10;
`endif

  logic        clk     = 1'b0;
  logic        rstn    = 1'b0;
  logic        tr_en   = 1'b1;
  logic        tx_req  = 1'b1;
  logic [15:0] comp    = 16'd3;
  logic [7:0]  tx_data = 8'h5A;
  logic        tx_ack;
  logic        tx_busy;
  logic        uart_tx;

  int checks   = 0;
  int errors   = 0;
  int ack_cnt  = 0;
  int ack_base = 0;

  uart_transmitter dut (
    .clk     (clk),
    .rstn    (rstn),
    .tr_en   (tr_en),
    .comp    (comp),
    .tx_data (tx_data),
    .tx_req  (tx_req),
    .tx_ack  (tx_ack),
    .tx_busy (tx_busy),
    .uart_tx (uart_tx)
  );

  always #5 clk = ~clk;

  // Inputs only change on the falling edge, so tx_ack is stable 1ns later.
  always @(negedge clk) begin
    #1;
    if (tx_ack === 1'b1) ack_cnt++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference frame: start 0, data LSB first, even parity if enabled, stop 1.
  task automatic build_frame(input logic [7:0] d, output bitq_t q);
    q = {};
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    begin
      int ones = 0;
      for (int i = 0; i < 8; i++) ones += int'(d[i]);
      q.push_back(bit'(ones % 2));
    end
`endif
    q.push_back(1'b1);
  endtask

  task automatic stretch(input bitq_t bits, input int cv, output bitq_t w);
    w = {};
    foreach (bits[k]) repeat (cv + 1) w.push_back(bits[k]);
  endtask

  // Called on a falling edge; returns on the falling edge where the start
  // bit is expected.
  task automatic request(input logic [7:0] d, input int cv);
    int n = 0;
    tx_data  = d;
    comp     = 16'(cv);
    tx_req   = 1'b1;
    ack_base = ack_cnt;
    #1;
    while (tx_ack !== 1'b1 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("ack seen", tx_ack, 1);
    @(negedge clk);
    tx_req  = 1'b0;
    tx_data = 8'($urandom);
  endtask

  // Compares the line cycle by cycle while scrambling tx_data and tx_req.
  task automatic expect_wave(input bitq_t w, input int exp_busy, input int chg_at, input int new_cv);
    int busy_n = 0;
    for (int i = 0; i < w.size(); i++) begin
      check("uart_tx", uart_tx, w[i]);
      if (tx_busy === 1'b1) busy_n++;
      if (i == chg_at) comp = 16'(new_cv);
      tx_data = 8'($urandom);
      tx_req  = (i < w.size() - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
    end
    check("busy cycles", busy_n, exp_busy);
    check("idle busy", tx_busy, 0);
    check("idle line", uart_tx, 1);
    check("ack count", ack_cnt - ack_base, 1);
  endtask

  initial begin
    vec_t       vecs[4];
    bitq_t      bits;
    bitq_t      bits2;
    bitq_t      w;
    logic [7:0] d;
    int         cv;
    int         base;
    int         n;

`ifdef UART_TX_PARITY_EN
    vecs[0] = '{8'hA5, 3, 11'b1_0_10100101_0, 11, 44};
    vecs[1] = '{8'h07, 1, 11'b1_1_00000111_0, 11, 22};
    vecs[2] = '{8'h3C, 0, 11'b1_0_00111100_0, 11, 11};
    vecs[3] = '{8'h80, 2, 11'b1_1_10000000_0, 11, 33};
`else
    vecs[0] = '{8'hA5, 3, 11'b0_1_10100101_0, 10, 40};
    vecs[1] = '{8'h07, 1, 11'b0_1_00000111_0, 10, 20};
    vecs[2] = '{8'h3C, 0, 11'b0_1_00111100_0, 10, 10};
    vecs[3] = '{8'h80, 2, 11'b0_1_10000000_0, 10, 30};
`endif

    // ---- reset state, with a pending request that must not be taken ----
    repeat (3) @(negedge clk);
    check("reset line", uart_tx, 1);
    check("reset busy", tx_busy, 0);
    check("reset ack", tx_ack, 0);
    rstn = 1'b1;
    #1;
    check("ack right after release", tx_ack, 0);
    tx_req = 1'b0;
    repeat (2) @(negedge clk);

    // ---- table-driven frames ----
    for (int v = 0; v < 4; v++) begin
      bits = {};
      for (int b = 0; b < vecs[v].nbits; b++) bits.push_back(vecs[v].seq[b]);
      stretch(bits, vecs[v].cv, w);
      request(vecs[v].data, vecs[v].cv);
      expect_wave(w, vecs[v].cycles, -1, 0);
    end

    // ---- back-to-back 0x00 then 0xFF, comp=0: stop stretched by 1 clk ----
    @(negedge clk);
    build_frame(8'h00, bits);
    build_frame(8'hFF, bits2);
    w = bits;
    w.push_back(1'b1);
    foreach (bits2[k]) w.push_back(bits2[k]);
    comp    = 16'd0;
    tx_data = 8'h00;
    tx_req  = 1'b1;
    base    = ack_cnt;
    n       = 0;
    #1;
    while (tx_ack !== 1'b1 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("b2b first ack", tx_ack, 1);
    @(negedge clk);
    tx_data = 8'hFF;
    for (int i = 0; i < w.size(); i++) begin
      check("b2b line", uart_tx, w[i]);
      if (i == FL) check("b2b gap busy", tx_busy, 0);
      if (i == FL + 1) tx_req = 1'b0;
      @(negedge clk);
    end
    check("b2b acks", ack_cnt - base, 2);
    check("b2b idle busy", tx_busy, 0);

    // ---- tr_en dropped during data bit 3 of 0x3C, comp=7 ----
    @(negedge clk);
    request(8'h3C, 7);
    repeat (34) @(negedge clk);
    check("pre-abort busy", tx_busy, 1);
    check("pre-abort line", uart_tx, 1);
    tr_en   = 1'b0;
    tx_req  = 1'b1;
    tx_data = 8'h3C;
    @(negedge clk);
    check("abort line", uart_tx, 1);
    check("abort busy", tx_busy, 0);
    check("abort no extra ack", ack_cnt - ack_base, 1);
    base = ack_cnt;
    repeat (6) @(negedge clk);
    check("disabled acks", ack_cnt - base, 0);
    check("disabled busy", tx_busy, 0);
    tr_en = 1'b1;
    build_frame(8'h3C, bits);
    stretch(bits, 7, w);
    request(8'h3C, 7);
    expect_wave(w, FL * 8, -1, 0);

    // ---- asynchronous reset mid-DATA, then 0x55 ----
    @(negedge clk);
    request(8'h00, 3);
    repeat (6) @(negedge clk);
    check("pre-reset line", uart_tx, 0);
    tx_req  = 1'b1;
    tx_data = 8'h55;
    #2;
    rstn = 1'b0;
    #1;
    check("async reset line", uart_tx, 1);
    check("async reset busy", tx_busy, 0);
    check("async reset ack", tx_ack, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    #1;
    check("ack at release", tx_ack, 0);
    @(negedge clk);
    build_frame(8'h55, bits);
    stretch(bits, 3, w);
    request(8'h55, 3);
    expect_wave(w, FL * 4, -1, 0);

    // ---- comp lowered 3 -> 1 while data bit 2 counts at 1 ----
    @(negedge clk);
    build_frame(8'hC3, bits);
    w = {};
    foreach (bits[k]) repeat ((k < 3) ? 4 : 2) w.push_back(bits[k]);
    request(8'hC3, 3);
    expect_wave(w, 3 * 4 + (FL - 3) * 2, 13, 1);

    // ---- randomized frames against the model ----
    for (int k = 0; k < 20; k++) begin
      d  = 8'($urandom);
      cv = $urandom_range(0, 4);
      repeat ($urandom_range(0, 3)) begin
        tx_data = 8'($urandom);
        @(negedge clk);
      end
      build_frame(d, bits);
      stretch(bits, cv, w);
      request(d, cv);
      expect_wave(w, bits.size() * (cv + 1), -1, 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_uart_transmitter
`default_nettype wire
